// File: rtl/ei_axi4_wr_arbiter.sv
// Two-master to one-slave AXI4 write-path arbiter with round-robin fairness.
// One write is outstanding at a time; the AW winner owns W and B until its B completes.
module ei_axi4_wr_arbiter #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int AW_PW  = ID_W + ADDR_W + 13,
   parameter int W_PW   = DATA_W + DATA_W/8 + 1,
   parameter int B_PW   = ID_W + 2
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [1:0]           m_awvalid,
   output logic [1:0]           m_awready,
   input  logic [2*AW_PW-1:0]   m_aw,
   input  logic [1:0]           m_wvalid,
   output logic [1:0]           m_wready,
   input  logic [2*W_PW-1:0]    m_w,
   output logic [1:0]           m_bvalid,
   input  logic [1:0]           m_bready,
   output logic [B_PW-1:0]      m_b,
   output logic                 s_awvalid,
   input  logic                 s_awready,
   output logic [AW_PW-1:0]     s_aw,
   output logic                 s_wvalid,
   input  logic                 s_wready,
   output logic [W_PW-1:0]      s_w,
   input  logic                 s_bvalid,
   output logic                 s_bready,
   input  logic [B_PW-1:0]      s_b,
   output logic [1:0]           grant,
   output logic                 busy,
   output logic                 wlast_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [1:0]  r_grant;
   logic [1:0]  w_nextGrant;
   logic        r_lastGrant;
   logic [7:0]  r_beatCnt;
   logic [7:0]  r_lenQ;
   logic        r_wlastErr;

   logic             w_owner;
   logic [AW_PW-1:0] w_awSel;
   logic [W_PW-1:0]  w_wSel;
   logic             w_winner;
   logic             w_awHs;
   logic             w_wHs;
   logic             w_bHs;
   logic             w_wlast;

   assign w_owner = r_grant[1];
   assign w_awSel = w_owner ? m_aw[AW_PW +: AW_PW] : m_aw[0 +: AW_PW];
   assign w_wSel  = w_owner ? m_w[W_PW +: W_PW]    : m_w[0 +: W_PW];
   assign w_wlast = w_wSel[0];

   // With both masters requesting, the one that was not served last wins.
   assign w_winner = (&m_awvalid) ? ~r_lastGrant : m_awvalid[1];

   assign grant     = r_grant;
   assign busy      = (r_state != IDLE);
   assign wlast_err = r_wlastErr;

   always_comb begin
      w_nextState = r_state;
      w_nextGrant = r_grant;
      w_awHs      = 1'b0;
      w_wHs       = 1'b0;
      w_bHs       = 1'b0;
      m_awready   = 2'b00;
      m_wready    = 2'b00;
      m_bvalid    = 2'b00;
      m_b         = '0;
      s_awvalid   = 1'b0;
      s_aw        = '0;
      s_wvalid    = 1'b0;
      s_w         = '0;
      s_bready    = 1'b0;
      case (r_state)
         IDLE: begin
            if (|m_awvalid) begin
               w_nextGrant = w_winner ? 2'b10 : 2'b01;
               w_nextState = ADDR;
            end
         end
         ADDR: begin
            s_awvalid          = m_awvalid[w_owner];
            s_aw               = w_awSel;
            m_awready[w_owner] = s_awready;
            w_awHs             = m_awvalid[w_owner] & s_awready;
            if (w_awHs) begin
               w_nextState = DATA;
            end
         end
         DATA: begin
            s_wvalid          = m_wvalid[w_owner];
            s_w               = w_wSel;
            m_wready[w_owner] = s_wready;
            w_wHs             = m_wvalid[w_owner] & s_wready;
            if (w_wHs && w_wlast) begin
               w_nextState = RESP;
            end
         end
         RESP: begin
            m_bvalid[w_owner] = s_bvalid;
            m_b               = s_b;
            s_bready          = m_bready[w_owner];
            w_bHs             = s_bvalid & m_bready[w_owner];
            if (w_bHs) begin
               w_nextGrant = 2'b00;
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextGrant = 2'b00;
         end
      endcase
   end

   // Beat counter saturates rather than wrapping so an overlong burst keeps flagging.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state     <= IDLE;
         r_grant     <= 2'b00;
         r_lastGrant <= 1'b1;
         r_beatCnt   <= 8'd0;
         r_lenQ      <= 8'd0;
         r_wlastErr  <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_grant    <= w_nextGrant;
         r_wlastErr <= w_wHs & (w_wlast ? (r_beatCnt != r_lenQ) : (r_beatCnt == r_lenQ));
         if (w_awHs) begin
            r_lenQ    <= w_awSel[12:5];
            r_beatCnt <= 8'd0;
         end else if (w_wHs && (r_beatCnt != 8'hFF)) begin
            r_beatCnt <= r_beatCnt + 8'd1;
         end
         if (w_bHs) begin
            r_lastGrant <= w_owner;
         end
      end
   end

   grantOneHot : assert property (@(posedge aclk) disable iff (areset) $onehot0(r_grant));

endmodule

// File: tb/tb_ei_axi4_wr_arbiter.sv
// Randomized scoreboard bench for ei_axi4_wr_arbiter: drivers queue expected
// transactions in service order, a negedge monitor checks every routed handshake.
module tb_ei_axi4_wr_arbiter;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int AW_PW  = ID_W + ADDR_W + 13;
   localparam int W_PW   = DATA_W + DATA_W/8 + 1;
   localparam int B_PW   = ID_W + 2;
   localparam int MAXT   = 128;
   localparam int BUDGET = 3000;

   logic                aclk;
   logic                areset;
   logic [1:0]          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic [2*AW_PW-1:0]  m_aw;
   logic [2*W_PW-1:0]   m_w;
   logic [B_PW-1:0]     m_b;
   logic                s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [AW_PW-1:0]    s_aw;
   logic [W_PW-1:0]     s_w;
   logic [B_PW-1:0]     s_b;
   logic [1:0]          grant;
   logic                busy;
   logic                wlast_err;

   logic                awv [2];
   logic [AW_PW-1:0]    awp [2];
   logic                wv  [2];
   logic [W_PW-1:0]     wp  [2];
   logic                brd [2];

   assign m_awvalid = {awv[1], awv[0]};
   assign m_aw      = {awp[1], awp[0]};
   assign m_wvalid  = {wv[1], wv[0]};
   assign m_w       = {wp[1], wp[0]};
   assign m_bready  = {brd[1], brd[0]};

   ei_axi4_wr_arbiter #(
      .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
   ) dut (
      .aclk(aclk), .areset(areset),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_b(m_b),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b(s_b),
      .grant(grant), .busy(busy), .wlast_err(wlast_err)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int passCount = 0;
   int totalCount = 0;

   // Transaction pool; expQ holds ids in the order the arbiter must serve them.
   int               txMaster [MAXT];
   logic [AW_PW-1:0] txAw     [MAXT];
   int               txN      [MAXT];
   int               txErr    [MAXT];
   logic [W_PW-1:0]  txBeats  [MAXT][8];
   int               nextId = 0;
   int               expQ[$];
   int               lastGrantModel = 1;

   int  awProb = 100;
   int  wProb  = 100;
   bit  monEn  = 1'b0;
   bit  noGaps = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      totalCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Expected WLAST-error pulses follow from how many beats precede/exceed awlen.
   function automatic int newTxn(input int m, input int len, input int n);
      int id;
      logic [DATA_W-1:0]   d;
      logic [DATA_W/8-1:0] st;
      id = nextId;
      nextId = (nextId + 1) % MAXT;
      txMaster[id] = m;
      txAw[id] = {ID_W'($urandom), ADDR_W'($urandom), 8'(len), 3'd2, 2'd1};
      txN[id] = n;
      txErr[id] = (n == len + 1) ? 0 : ((n < len + 1) ? 1 : 2);
      for (int k = 0; k < 8; k++) begin
         d  = DATA_W'($urandom);
         st = (DATA_W/8)'($urandom);
         txBeats[id][k] = {d, st, (k == n - 1)};
      end
      return id;
   endfunction

   task automatic waitHs(input int which, input int m, input string nm, output bit ok);
      int cyc;
      logic rdy;
      ok = 1'b0;
      cyc = 0;
      while (1) begin
         @(negedge aclk);
         if (areset) return;
         rdy = (which == 0) ? m_awready[m] : (which == 1) ? m_wready[m] : m_bvalid[m];
         if (rdy) ok = 1'b1;
         @(posedge aclk);
         #1;
         if (ok) return;
         cyc++;
         if (cyc > BUDGET) begin
            checkOutput({nm, "Timeout"}, 64'(cyc), 64'(BUDGET));
            return;
         end
      end
   endtask

   task automatic driveAw(input int id, input bit lat);
      int m;
      bit ok;
      m = txMaster[id];
      awv[m] = 1'b1;
      awp[m] = txAw[id];
      ok = 1'b0;
      if (lat) begin
         @(negedge aclk);
         checkOutput("awIdleNoValid", 64'(s_awvalid), 64'd0);
         checkOutput("awIdleNoReady", 64'(m_awready), 64'd0);
         checkOutput("idleNotBusy", 64'(busy), 64'd0);
         @(posedge aclk);
         #1;
         @(negedge aclk);
         checkOutput("awLatency", 64'(s_awvalid), 64'd1);
         ok = m_awready[m];
         @(posedge aclk);
         #1;
      end
      if (!ok) waitHs(0, m, "aw", ok);
      awv[m] = 1'b0;
      awp[m] = '0;
   endtask

   task automatic driveW(input int id);
      int m;
      bit ok;
      m = txMaster[id];
      for (int k = 0; k < txN[id]; k++) begin
         if (!noGaps) repeat ($urandom_range(0, 2)) begin
            @(posedge aclk);
            #1;
         end
         if (areset) break;
         wv[m] = 1'b1;
         wp[m] = txBeats[id][k];
         waitHs(1, m, "w", ok);
         wv[m] = 1'b0;
         wp[m] = '0;
         if (!ok) break;
      end
   endtask

   task automatic driveB(input int id);
      int m;
      bit ok;
      m = txMaster[id];
      repeat ($urandom_range(0, 3)) begin
         @(posedge aclk);
         #1;
      end
      brd[m] = 1'b1;
      waitHs(2, m, "b", ok);
      brd[m] = 1'b0;
   endtask

   task automatic masterProc(input int id, input bit lat);
      fork
         driveAw(id, lat);
         driveW(id);
      join
      if (!areset) driveB(id);
   endtask

   // Issue one or two simultaneous requests; the model orders them by round-robin.
   task automatic applyStimulus(input bit use0, input bit use1, input int len0, input int n0,
                                input int len1, input int n1, input bit lat);
      int id0, id1;
      id0 = newTxn(0, len0, n0);
      id1 = newTxn(1, len1, n1);
      if (use0 && use1) begin
         if (lastGrantModel == 1) begin
            expQ.push_back(id0);
            expQ.push_back(id1);
            lastGrantModel = 1;
         end else begin
            expQ.push_back(id1);
            expQ.push_back(id0);
            lastGrantModel = 0;
         end
      end else if (use0) begin
         expQ.push_back(id0);
         lastGrantModel = 0;
      end else begin
         expQ.push_back(id1);
         lastGrantModel = 1;
      end
      fork
         begin if (use0) masterProc(id0, lat); end
         begin if (use1) masterProc(id1, 1'b0); end
      join
      repeat (2) begin
         @(posedge aclk);
         #1;
      end
   endtask

   // Slave model: random readiness, one B per completed burst.
   initial begin
      bit hsW, hsB, pend;
      int dly;
      s_awready = 1'b0;
      s_wready  = 1'b0;
      s_bvalid  = 1'b0;
      s_b       = '0;
      pend = 1'b0;
      dly  = 0;
      forever begin
         @(negedge aclk);
         hsW = s_wvalid && s_wready && s_w[0];
         hsB = s_bvalid && s_bready;
         @(posedge aclk);
         #1;
         if (areset) begin
            s_awready = 1'b0;
            s_wready  = 1'b0;
            s_bvalid  = 1'b0;
            s_b       = '0;
            pend      = 1'b0;
            continue;
         end
         s_awready = ($urandom_range(0, 99) < awProb);
         s_wready  = ($urandom_range(0, 99) < wProb);
         if (hsB) begin
            s_bvalid = 1'b0;
            s_b      = '0;
         end
         if (hsW) begin
            pend = 1'b1;
            dly  = $urandom_range(0, 3);
         end
         if (pend && !s_bvalid) begin
            if (dly == 0) begin
               s_bvalid = 1'b1;
               s_b      = B_PW'($urandom);
               pend     = 1'b0;
            end else begin
               dly--;
            end
         end
      end
   end

   // Monitor: compares each routed handshake against the head of the scoreboard.
   initial begin
      int curId, beatIdx, errCnt;
      logic [1:0] own;
      curId = -1;
      beatIdx = 0;
      errCnt = 0;
      own = 2'b00;
      forever begin
         @(negedge aclk);
         if (!monEn) begin
            curId = -1;
            continue;
         end
         if (wlast_err) errCnt++;
         if (s_awvalid && s_awready) begin
            if (expQ.size() == 0) begin
               checkOutput("awUnexpected", 64'(s_aw), 64'd0);
            end else begin
               curId = expQ[0];
               own = 2'(1 << txMaster[curId]);
               beatIdx = 0;
               errCnt = 0;
               checkOutput("awPayload", 64'(s_aw), 64'(txAw[curId]));
               checkOutput("awGrant", 64'(grant), 64'(own));
               checkOutput("awReadyRoute", 64'(m_awready), 64'(own));
            end
         end
         if (s_wvalid && s_wready && curId >= 0) begin
            if (beatIdx < 8) checkOutput("wPayload", 64'(s_w), 64'(txBeats[curId][beatIdx]));
            checkOutput("wReadyRoute", 64'(m_wready), 64'(own));
            beatIdx++;
         end
         if (((m_bvalid & m_bready) != 2'b00) && curId >= 0) begin
            checkOutput("bValidRoute", 64'(m_bvalid), 64'(own));
            checkOutput("bPayload", 64'(m_b), 64'(s_b));
            checkOutput("beatCount", 64'(beatIdx), 64'(txN[curId]));
            checkOutput("wlastErrCount", 64'(errCnt), 64'(txErr[curId]));
            void'(expQ.pop_front());
            curId = -1;
         end
      end
   end

   initial begin
      int wBeats;
      int sel, len, n, mode;
      for (int i = 0; i < 2; i++) begin
         awv[i] = 1'b0; awp[i] = '0; wv[i] = 1'b0; wp[i] = '0; brd[i] = 1'b0;
      end
      areset = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      checkOutput("rstGrant", 64'(grant), 64'd0);
      checkOutput("rstBusy", 64'(busy), 64'd0);
      checkOutput("rstSAwValid", 64'(s_awvalid), 64'd0);
      checkOutput("rstSAw", 64'(s_aw), 64'd0);
      checkOutput("rstWlastErr", 64'(wlast_err), 64'd0);
      areset = 1'b0;
      @(posedge aclk);
      #1;
      monEn = 1'b1;

      applyStimulus(1'b1, 1'b0, 3, 4, 0, 1, 1'b1);
      checkOutput("idleGrantZero", 64'(grant), 64'd0);
      applyStimulus(1'b1, 1'b1, 0, 1, 0, 1, 1'b0);
      applyStimulus(1'b1, 1'b1, 0, 1, 0, 1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1, 1, 0, 1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1, 3, 0, 1, 1'b0);

      for (int r = 0; r < 30; r++) begin
         awProb = $urandom_range(30, 100);
         wProb  = $urandom_range(30, 100);
         sel = $urandom_range(1, 3);
         len = $urandom_range(0, 5);
         mode = $urandom_range(0, 5);
         n = (mode == 0 && len > 0) ? len : (mode == 1) ? len + 2 : len + 1;
         applyStimulus((sel & 1) != 0, (sel & 2) != 0, len, n,
                       $urandom_range(0, 5), $urandom_range(1, 6), 1'b0);
      end
      checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);

      // Abandon an M0 burst with reset after its second data beat.
      monEn = 1'b0;
      noGaps = 1'b1;
      awProb = 100;
      wProb = 100;
      begin
         int id;
         id = newTxn(0, 3, 4);
         fork
            masterProc(id, 1'b0);
            begin
               wBeats = 0;
               while (wBeats < 2) begin
                  @(negedge aclk);
                  if (s_wvalid && s_wready) wBeats++;
               end
               @(posedge aclk);
               #2;
               areset = 1'b1;
               #1;
               checkOutput("midRstGrant", 64'(grant), 64'd0);
               checkOutput("midRstBusy", 64'(busy), 64'd0);
               checkOutput("midRstSWValid", 64'(s_wvalid), 64'd0);
               checkOutput("midRstSW", 64'(s_w), 64'd0);
               checkOutput("midRstMWReady", 64'(m_wready), 64'd0);
               checkOutput("midRstMBValid", 64'(m_bvalid), 64'd0);
            end
         join
      end
      for (int i = 0; i < 2; i++) begin
         awv[i] = 1'b0; awp[i] = '0; wv[i] = 1'b0; wp[i] = '0; brd[i] = 1'b0;
      end
      repeat (2) @(posedge aclk);
      #1;
      areset = 1'b0;
      noGaps = 1'b0;
      lastGrantModel = 1;
      @(posedge aclk);
      #1;
      monEn = 1'b1;
      applyStimulus(1'b0, 1'b1, 2, 3, 2, 3, 1'b0);
      applyStimulus(1'b1, 1'b1, 1, 2, 1, 2, 1'b0);
      checkOutput("finalScoreboardEmpty", 64'(expQ.size()), 64'd0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
